// File: rtl/hilo_mdu_sequencer_if.sv
// ============================================================================
// Module   : hilo_mdu_sequencer_if
// Brief    : Issue/result bus between the pipeline and the HI/LO MDU sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hilo_mdu_sequencer_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        ReadReq;
    logic        Flush;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, Op, A, B, ReadReq, Flush,
        input  Busy, Stall, Done, HI, LO
    );

    modport slave (
        input  Start, Op, A, B, ReadReq, Flush,
        output Busy, Stall, Done, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/hilo_mdu_sequencer.sv
// ============================================================================
// Module   : hilo_mdu_sequencer
// Brief    : Iterative shift-add MULT/MULTU/MADD/MSUB unit owning HI/LO; MTHI/MTLO.
//            Optional macro MDU_EARLY_OUT_EN ends RUN once the multiplier is exhausted.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hilo_mdu_sequencer #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    hilo_mdu_sequencer_if.slave bus
);

    localparam int         c_N    = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] c_LAST = 6'(c_N - 1);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_MADD  = 3'b010;
    localparam logic [2:0] c_OP_MSUB  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic        r_neg;
    logic [1:0]  r_op;
    logic [5:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_idle_start;
    logic        w_is_mul;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_pp;
    logic [31:0] w_mplier_nxt;
    logic        w_run_last;
    logic [63:0] w_prod;
    logic [63:0] w_fix_res;

    assign w_idle_start = (r_state == S_IDLE) & bus.Start & ~bus.Flush;
    assign w_is_mul     = ~bus.Op[2];
    assign w_signed     = (bus.Op != c_OP_MULTU);
    // Magnitude of -2^31 wraps to 0x80000000, which is the correct unsigned value
    assign w_mag_a      = (w_signed && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    assign w_mag_b      = (w_signed && bus.B[31]) ? (32'd0 - bus.B) : bus.B;

    always_comb begin
        w_pp = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_mplier[k]) begin
                w_pp = w_pp + (r_mcand << k);
            end
        end
    end

    assign w_mplier_nxt = r_mplier >> BITS_PER_CYCLE;

`ifdef MDU_EARLY_OUT_EN
    assign w_run_last = (w_mplier_nxt == 32'd0) || (r_count == c_LAST);
`else
    assign w_run_last = (r_count == c_LAST);
`endif

    assign w_prod = r_neg ? (64'd0 - r_acc) : r_acc;

    always_comb begin
        w_fix_res = w_prod;
        case (r_op)
            c_OP_MADD[1:0]: w_fix_res = {r_hi, r_lo} + w_prod;
            c_OP_MSUB[1:0]: w_fix_res = {r_hi, r_lo} - w_prod;
            default:        w_fix_res = w_prod;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_idle_start && w_is_mul) w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.Flush)       w_state_nxt = S_IDLE;
                else if (w_run_last) w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_op     <= '0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_idle_start) begin
                        case (bus.Op)
                            c_OP_MTHI: begin
                                r_hi   <= bus.A;
                                r_done <= 1'b1;
                            end
                            c_OP_MTLO: begin
                                r_lo   <= bus.A;
                                r_done <= 1'b1;
                            end
                            c_OP_MULT, c_OP_MULTU, c_OP_MADD, c_OP_MSUB: begin
                                r_mcand  <= {32'd0, w_mag_a};
                                r_mplier <= w_mag_b;
                                r_neg    <= w_signed & (bus.A[31] ^ bus.B[31]);
                                r_op     <= bus.Op[1:0];
                                r_acc    <= '0;
                                r_count  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (!bus.Flush) begin
                        r_acc    <= r_acc + w_pp;
                        r_mplier <= w_mplier_nxt;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_count  <= r_count + 6'd1;
                    end
                end
                S_FIX: begin
                    if (!bus.Flush) begin
                        {r_hi, r_lo} <= w_fix_res;
                        r_done       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy  = (r_state == S_RUN) || (r_state == S_FIX);
    assign bus.Stall = bus.Busy & (bus.Start | bus.ReadReq);
    assign bus.Done  = r_done;
    assign bus.HI    = r_hi;
    assign bus.LO    = r_lo;

endmodule

`default_nettype wire

// File: doc/hilo_mdu_sequencer.md
Name: hilo_mdu_sequencer

Overview:
- Multi-cycle multiply/accumulate unit that owns the architectural HI/LO register pair.
- Sequences iterative shift-add multiplication for MULT, MULTU, MADD and MSUB; performs single-cycle MTHI and MTLO.
- Sits beside the EX-stage ALU; the ALU reads HI and LO for MFHI/MFLO.
- Drives Stall to the pipeline hazard logic while a multiply is in flight.

Parameters:
BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4, 8; RUN length N = 32/BITS_PER_CYCLE

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request to issue Op with operands A and B
Op  input  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO; 110 and 111 are no-op
A  input  32  operand A (rs)
B  input  32  operand B (rt)
ReadReq  input  1  pipeline is executing MFHI or MFLO this cycle
Flush  input  1  synchronous abort of the in-flight operation
Busy  output  1  high in the RUN and FIX states
Stall  output  1  combinational: Busy & (Start | ReadReq)
Done  output  1  one-cycle pulse; HI and LO already hold the new value in that cycle
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, any state): state=IDLE; HI=0, LO=0; Busy=0, Done=0; all internal datapath registers cleared.
- Done is registered. It defaults to 0 every cycle unless set by the rules below.
- FSM states: IDLE, RUN, FIX.
- IDLE, Start=1, Op=MTHI: HI<=A; Done=1 next cycle; remain in IDLE.
- IDLE, Start=1, Op=MTLO: LO<=A; Done=1 next cycle; remain in IDLE.
- IDLE, Start=1, multiply op:
  - capture mcand=|A| and mplier=|B| for signed ops, or raw A and B for MULTU;
  - capture neg=A[31]^B[31] (forced to 0 for MULTU);
  - capture the op; clear the 64-bit product accumulator; go to RUN with count=0.
- RUN, each cycle: add the partial products of the low BITS_PER_CYCLE bits of mplier into the accumulator; shift mplier right and mcand left by BITS_PER_CYCLE; count+1. After N cycles go to FIX.
- FIX, one cycle: p = neg ? -acc : acc (64-bit two's complement).
  - MULT/MULTU: {HI,LO}<=p.
  - MADD: {HI,LO}<={HI,LO}+p.
  - MSUB: {HI,LO}<={HI,LO}-p.
  - All arithmetic is modulo 2^64.
  - Go to IDLE; Done=1 next cycle.
- Latency: Start sampled at edge t. New HI/LO and Done are visible in the cycle after edge t+N+1 (34 cycles for BITS_PER_CYCLE=1). Start may be issued in that same Done cycle.
- Start while Busy: ignored; the pipeline holds the instruction via Stall.
- Operand A, B and Op changes after capture have no effect.
- Op 110/111 with Start: no state change, no Done.
- ReadReq while Busy: Stall=1. ReadReq in IDLE: Stall=0, and HI/LO reflect all completed ops.
- Flush in RUN or FIX: state<=IDLE at the next edge; HI/LO unchanged; no Done.
- Flush in IDLE with Start: Flush wins; Start is dropped, including MTHI/MTLO.
- HI/LO are written only by MTHI, MTLO and FIX; MADD/MSUB read {HI,LO} in FIX.
- -2^31 operands: take the magnitude as the unsigned 32-bit value 0x80000000. MULT 0x80000000 x 0x80000000 gives HI=0x40000000, LO=0.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: in RUN, move to FIX at the edge where the post-shift mplier is zero, with a minimum of one RUN cycle. Latency is variable, and results are identical to the fixed-latency build.
- Undefined: always N RUN cycles; fixed latency.

Test Plan:
- Reset asserted mid-RUN -> HI=0, LO=0, Busy=0, Done=0 immediately (async); the next Start begins cleanly.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done 34 cycles later; HI=0xFFFFFFFE, LO=0x00000001; Busy high for 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MTHI A=0, MTLO A=10, MADD A=2 B=3 -> LO=16.
- Then MSUB A=4, B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFFC.
- MULT issued, then ReadReq=1 and a second Start every busy cycle -> Stall=1 on all those cycles; second Start ignored; HI/LO equal only the first product.
- Flush at RUN cycle 10 of MADD with HI=1, LO=2 -> Busy=0 next cycle; HI=1, LO=2; no Done pulse.
